// File: rtl/pit_modulus_counter.sv
// Down-counting modulus stage of the PIT: reloads from a programmable modulus on
// each rollover, keeps a sticky flag/interrupt and emits a rollover pulse for slaves.
module pit_modulus_counter #(
   parameter int unsigned COUNT_SIZE = 16
) (
   input  logic                  bus_clk,
   input  logic                  async_rst,
   input  logic                  sync_reset,
   input  logic                  pit_cnte,
   input  logic                  pit_ien,
   input  logic                  mod_wr,
   input  logic [COUNT_SIZE-1:0] mod_value,
   input  logic                  force_load,
   input  logic                  flag_clr,
   input  logic                  prescale_tick,
   input  logic                  counter_sync,
   output logic                  cnt_sync_o,
   output logic [COUNT_SIZE-1:0] cnt_n,
   output logic                  pit_flg,
   output logic                  pit_irq_o,
   output logic                  pit_o
);

   logic [COUNT_SIZE-1:0] mod_reg;
   logic [COUNT_SIZE-1:0] next_mod;
   logic                  rollover;

   // A modulus write in the same cycle as a reload wins over the stored value.
   assign next_mod  = mod_wr ? mod_value : mod_reg;
   assign rollover  = counter_sync && prescale_tick && (cnt_n == COUNT_SIZE'(1)) && !force_load;
   assign pit_o     = rollover;
   assign pit_irq_o = pit_flg && pit_ien;

   always_ff @(posedge bus_clk or posedge async_rst) begin
      if (async_rst) begin
         mod_reg    <= '0;
         cnt_n      <= '0;
         pit_flg    <= 1'b0;
         cnt_sync_o <= 1'b0;
      end else if (sync_reset) begin
         mod_reg    <= '0;
         cnt_n      <= '0;
         pit_flg    <= 1'b0;
         cnt_sync_o <= 1'b0;
      end else begin
         cnt_sync_o <= pit_cnte;

         if (mod_wr) begin
            mod_reg <= mod_value;
         end

         // Disabled counter sits preloaded so counting restarts from the full modulus.
         if (!counter_sync || force_load || rollover) begin
            cnt_n <= next_mod;
         end else if (prescale_tick) begin
            cnt_n <= cnt_n - COUNT_SIZE'(1);
         end

         if (rollover) begin
            pit_flg <= 1'b1;
         end else if (flag_clr) begin
            pit_flg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pit_modulus_counter.sv
// Directed bench for pit_modulus_counter (COUNT_SIZE = 4) with hand-computed expectations.
module tb_pit_modulus_counter;

   localparam int unsigned CS = 4;

   logic          bus_clk;
   logic          async_rst;
   logic          sync_reset;
   logic          pit_cnte;
   logic          pit_ien;
   logic          mod_wr;
   logic [CS-1:0] mod_value;
   logic          force_load;
   logic          flag_clr;
   logic          prescale_tick;
   logic          counter_sync;
   logic          cnt_sync_o;
   logic [CS-1:0] cnt_n;
   logic          pit_flg;
   logic          pit_irq_o;
   logic          pit_o;

   int vectors;
   int miscompares;

   pit_modulus_counter #(.COUNT_SIZE(CS)) dut (
      .bus_clk       (bus_clk),
      .async_rst     (async_rst),
      .sync_reset    (sync_reset),
      .pit_cnte      (pit_cnte),
      .pit_ien       (pit_ien),
      .mod_wr        (mod_wr),
      .mod_value     (mod_value),
      .force_load    (force_load),
      .flag_clr      (flag_clr),
      .prescale_tick (prescale_tick),
      .counter_sync  (counter_sync),
      .cnt_sync_o    (cnt_sync_o),
      .cnt_n         (cnt_n),
      .pit_flg       (pit_flg),
      .pit_irq_o     (pit_irq_o),
      .pit_o         (pit_o)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge bus_clk);
      #1;
   endtask

   initial begin
      int first;
      int second;
      vectors     = 0;
      miscompares = 0;
      async_rst     = 1'b1;
      sync_reset    = 1'b0;
      pit_cnte      = 1'b0;
      pit_ien       = 1'b0;
      mod_wr        = 1'b0;
      mod_value     = '0;
      force_load    = 1'b0;
      flag_clr      = 1'b0;
      prescale_tick = 1'b0;
      counter_sync  = 1'b0;
      cyc();
      cyc();
      chk("rst_cnt", 32'(cnt_n), 0);
      chk("rst_flg", 32'(pit_flg), 0);
      chk("rst_sync", 32'(cnt_sync_o), 0);
      async_rst = 1'b0;

      // program mod 5 and count, then async reset mid-count
      mod_wr = 1'b1; mod_value = 4'd5; pit_cnte = 1'b1; pit_ien = 1'b1;
      cyc();
      chk("pre5_cnt", 32'(cnt_n), 5);
      chk("pre5_sync", 32'(cnt_sync_o), 1);
      mod_wr = 1'b0; counter_sync = 1'b1; prescale_tick = 1'b1;
      cyc();
      cyc();
      chk("run5_cnt", 32'(cnt_n), 3);
      async_rst = 1'b1;
      #1;
      chk("arst_cnt", 32'(cnt_n), 0);
      chk("arst_flg", 32'(pit_flg), 0);
      chk("arst_sync", 32'(cnt_sync_o), 0);
      chk("arst_pito", 32'(pit_o), 0);
      chk("arst_irq", 32'(pit_irq_o), 0);
      async_rst = 1'b0; counter_sync = 1'b0; prescale_tick = 1'b0;
      cyc();

      // mod 3 with a tick every cycle
      mod_wr = 1'b1; mod_value = 4'd3;
      cyc();
      mod_wr = 1'b0; counter_sync = 1'b1; prescale_tick = 1'b1;
      #1;
      for (int i = 0; i < 7; i++) begin
         chk("m3_cnt", 32'(cnt_n), 32'(3 - (i % 3)));
         chk("m3_pito", 32'(pit_o), ((i % 3) == 2) ? 32'd1 : 32'd0);
         chk("m3_flg", 32'(pit_flg), (i >= 3) ? 32'd1 : 32'd0);
         chk("m3_irq", 32'(pit_irq_o), (i >= 3) ? 32'd1 : 32'd0);
         cyc();
      end
      chk("m3_cnt7", 32'(cnt_n), 2);
      pit_ien = 1'b0;
      #1;
      chk("mask_irq", 32'(pit_irq_o), 0);
      chk("mask_flg", 32'(pit_flg), 1);

      // clear alone, then clear coincident with a rollover
      flag_clr = 1'b1;
      cyc();
      chk("clr_flg", 32'(pit_flg), 0);
      chk("clr_pito", 32'(pit_o), 1);
      cyc();
      chk("setwin_flg", 32'(pit_flg), 1);
      chk("setwin_cnt", 32'(cnt_n), 3);
      flag_clr = 1'b0;

      // mod 1: rollover every tick
      counter_sync = 1'b0; mod_wr = 1'b1; mod_value = 4'd1;
      cyc();
      mod_wr = 1'b0; counter_sync = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("m1_cnt", 32'(cnt_n), 1);
         chk("m1_pito", 32'(pit_o), 1);
         cyc();
      end

      // mod 0: 16 ticks per period
      counter_sync = 1'b0; mod_wr = 1'b1; mod_value = 4'd0;
      cyc();
      mod_wr = 1'b0; counter_sync = 1'b1;
      #1;
      chk("m0_cnt", 32'(cnt_n), 0);
      first  = -1;
      second = -1;
      for (int c = 0; c < 40; c++) begin
         if (pit_o) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         cyc();
      end
      chk("m0_first", 32'(first), 15);
      chk("m0_period", 32'(second - first), 16);

      // modulus write while running takes effect at the next reload
      counter_sync = 1'b0; mod_wr = 1'b1; mod_value = 4'd4;
      cyc();
      mod_wr = 1'b0; counter_sync = 1'b1;
      #1;
      chk("m4_cnt", 32'(cnt_n), 4);
      cyc();
      cyc();
      chk("m4_cnt2", 32'(cnt_n), 2);
      mod_wr = 1'b1; mod_value = 4'd7;
      cyc();
      mod_wr = 1'b0;
      #1;
      chk("wr_cnt1", 32'(cnt_n), 1);
      chk("wr_pito", 32'(pit_o), 1);
      cyc();
      chk("wr_reload7", 32'(cnt_n), 7);
      for (int i = 0; i < 6; i++) cyc();
      chk("m7_cnt1", 32'(cnt_n), 1);
      mod_wr = 1'b1; mod_value = 4'd9;
      cyc();
      mod_wr = 1'b0;
      chk("wrroll_cnt", 32'(cnt_n), 9);

      // counter_sync drop mid-count
      flag_clr = 1'b1;
      cyc();
      flag_clr = 1'b0;
      chk("pre_drop_flg", 32'(pit_flg), 0);
      counter_sync = 1'b0; mod_wr = 1'b1; mod_value = 4'd5;
      cyc();
      mod_wr = 1'b0; counter_sync = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("drop_at2", 32'(cnt_n), 2);
      counter_sync = 1'b0;
      cyc();
      chk("drop_cnt", 32'(cnt_n), 5);
      chk("drop_flg", 32'(pit_flg), 0);
      cyc();
      chk("drop_hold", 32'(cnt_n), 5);
      chk("drop_pito", 32'(pit_o), 0);
      counter_sync = 1'b1;
      cyc();
      chk("restart_cnt", 32'(cnt_n), 4);

      // force_load at cnt 1 with a tick present
      cyc();
      cyc();
      cyc();
      chk("fl_at1", 32'(cnt_n), 1);
      force_load = 1'b1;
      #1;
      chk("fl_pito", 32'(pit_o), 0);
      cyc();
      force_load = 1'b0;
      chk("fl_cnt", 32'(cnt_n), 5);
      chk("fl_flg", 32'(pit_flg), 0);

      // synchronous reset acts at the edge and clears the modulus
      sync_reset = 1'b1;
      #1;
      chk("srst_pre", 32'(cnt_n), 5);
      cyc();
      sync_reset = 1'b0;
      chk("srst_cnt", 32'(cnt_n), 0);
      chk("srst_sync", 32'(cnt_sync_o), 0);
      counter_sync = 1'b0;
      cyc();
      chk("srst_mod", 32'(cnt_n), 0);
      chk("srst_sync2", 32'(cnt_sync_o), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pit_modulus_counter.md
Name: pit_modulus_counter

Overview:
Down-counting modulus stage of the PIT. It sits directly downstream of the prescaler and consumes its prescale_out tick and counter_sync enable. It also produces the cnt_sync_o enable that the prescaler uses. It reloads from a programmable modulus on each rollover, raises a sticky flag and interrupt, and emits a one-cycle rollover pulse for slave PITs.

Parameters:
COUNT_SIZE, 16, width of the modulus register and down-counter.

Ports:
bus_clk  input  1  reference clock; all state on rising edge.
async_rst  input  1  asynchronous reset, active-high.
sync_reset  input  1  synchronous reset, active-high; same effect as async_rst, applied at the clock edge.
pit_cnte  input  1  counter enable from the control register.
pit_ien  input  1  interrupt enable.
mod_wr  input  1  modulus write strobe.
mod_value  input  COUNT_SIZE  modulus write data.
force_load  input  1  reload the counter from the modulus without setting the flag.
flag_clr  input  1  write-1-to-clear for pit_flg.
prescale_tick  input  1  tick from the prescaler (its prescale_out).
counter_sync  input  1  count enable from the prescaler (already muxed for master or slave mode).
cnt_sync_o  output  1  registered pit_cnte; drives the prescaler enable.
cnt_n  output  COUNT_SIZE  current count value.
pit_flg  output  1  sticky rollover flag.
pit_irq_o  output  1  interrupt request.
pit_o  output  1  rollover pulse to slave PITs.

Behaviour:
- Reset (async_rst high, or sync_reset at the edge):
  - mod_reg = 0, cnt_n = 0.
  - pit_flg = 0, cnt_sync_o = 0.
  - pit_o and pit_irq_o therefore read 0.
- cnt_sync_o: registered copy of pit_cnte. One-cycle latency from pit_cnte to the prescaler enable.
- mod_reg: loads mod_value at the edge where mod_wr is high. No other writer.
- rollover (combinational) = counter_sync && prescale_tick && (cnt_n == 1) && !force_load.
- pit_o = rollover. It is combinational, lasts exactly one bus_clk cycle per rollover and has no register delay.
- Counter update priority, highest first:
  1. Reset.
  2. counter_sync low: cnt_n <= next_mod (preload; holds while disabled).
  3. force_load: cnt_n <= next_mod.
  4. rollover: cnt_n <= next_mod.
  5. counter_sync && prescale_tick: cnt_n <= cnt_n - 1, modulo 2^COUNT_SIZE.
  6. Otherwise hold.
- next_mod = mod_wr ? mod_value : mod_reg. A write is therefore visible in the same-edge reload (the write wins over the old value).
- A mod_wr while running does not disturb cnt_n. The new modulus takes effect at the next rollover or force_load.
- Period is M ticks for modulus M ≥ 1.
  - M = 1: rollover on every tick.
  - M = 0: 0 - 1 wraps to all-ones, giving a period of 2^COUNT_SIZE ticks.
  - The first rollover after a preload from 0 occurs after 2^COUNT_SIZE ticks.
- pit_flg:
  - Set at the edge following a rollover.
  - Cleared at the edge where flag_clr is high.
  - Set and clear in the same cycle: set wins (the flag stays 1).
  - Not affected by pit_cnte or force_load.
- pit_irq_o = pit_flg && pit_ien (combinational). Dropping pit_ien masks the interrupt but keeps the flag.
- counter_sync falling mid-count: cnt_n preloads next_mod on the following edge. No rollover or flag results. Counting restarts from the full modulus when re-enabled.
- prescale_tick with counter_sync low is ignored.
- Reset mid-count: all state returns to reset values immediately (async) or at the edge (sync). mod_reg is lost and must be rewritten.

Test Plan:
- Reset with mod_reg programmed to 5 and counting → cnt_n = 0, pit_flg = 0, cnt_sync_o = 0, pit_o = 0, pit_irq_o = 0.
- Write mod 3, pit_cnte = 1, counter_sync = 1, tick every cycle:
  - cnt_n sequence 3, 2, 1, 3, 2, 1 …
  - pit_o high exactly during the cycles where cnt_n = 1.
  - pit_flg rises the next cycle.
  - pit_irq_o follows pit_flg only when pit_ien = 1.
- Mod 1, continuous ticks → pit_o high every cycle and cnt_n stuck at 1. Mod 0 with COUNT_SIZE = 4 → 16 ticks between pit_o pulses.
- While at cnt_n = 2 with mod 4, write mod 7:
  - The count continues 2, 1.
  - The reload gives 7.
  - mod_wr coincident with a rollover reloads mod_value directly.
- flag_clr asserted in the same cycle as a rollover → pit_flg remains 1. flag_clr alone → pit_flg = 0 next edge.
- counter_sync dropped at cnt_n = 2 (mod 5) → cnt_n = 5 next edge and no flag. force_load at cnt_n = 1 with a tick present → cnt_n = mod, no pit_o, no flag.
